// File: rtl/load_store_unit_if.sv
// Execute-stage / data-memory bundle of the load/store unit.
// master = the unit itself, slave = the core and memory side.
interface load_store_unit_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic              is_store;
   logic [2:0]        funct3;
   logic [31:0]       eff_addr;
   logic [31:0]       store_data;
   logic              mem_request;
   logic              mem_we_re;
   logic [3:0]        mem_masking;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_w_data;
   logic              mem_valid;
   logic [31:0]       mem_r_data;
   logic              stall;
   logic              done;
   logic [31:0]       load_data;
   logic              addr_err;
   logic              timeout;

   modport master (
      input  start, is_store, funct3, eff_addr, store_data, mem_valid, mem_r_data,
      output mem_request, mem_we_re, mem_masking, mem_address, mem_w_data,
             stall, done, load_data, addr_err, timeout
   );

   modport slave (
      output start, is_store, funct3, eff_addr, store_data, mem_valid, mem_r_data,
      input  mem_request, mem_we_re, mem_masking, mem_address, mem_w_data,
             stall, done, load_data, addr_err, timeout
   );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: aligns stores, issues a single memory
// request, extends load data, and flags illegal accesses and memory timeouts.
module load_store_unit #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              mem_request_q, mem_request_d;
   logic              mem_we_re_q, mem_we_re_d;
   logic [3:0]        mem_masking_q, mem_masking_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [31:0]       mem_w_data_q, mem_w_data_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic              done_q, done_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              addr_err_q, addr_err_d;
   logic              timeout_q, timeout_d;

   logic [31:0] byte_rep;
   logic [31:0] half_rep;
   logic [7:0]  r_bytes [4];
   logic        acc_legal;
   logic [3:0]  acc_mask;
   logic [31:0] acc_wdata;
   logic [7:0]  r_byte;
   logic [15:0] r_half;
   logic [31:0] r_ext;

   // Store lanes are replicated so memory only needs the byte enables.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lanes
         assign byte_rep[8*gi +: 8] = bus.store_data[7:0];
         assign r_bytes[gi]         = bus.mem_r_data[8*gi +: 8];
      end
      for (genvar gi = 0; gi < 2; gi++) begin : g_half_lanes
         assign half_rep[16*gi +: 16] = bus.store_data[15:0];
      end
      if (ADDR_W < 30) begin : g_hi_addr
         logic unused_hi_addr;
         assign unused_hi_addr = ^bus.eff_addr[31:ADDR_W+2];
      end
   endgenerate

   always_comb begin
      acc_legal = 1'b0;
      case (bus.funct3)
         3'b000:  acc_legal = 1'b1;
         3'b001:  acc_legal = ~bus.eff_addr[0];
         3'b010:  acc_legal = (bus.eff_addr[1:0] == 2'b00);
         3'b100:  acc_legal = ~bus.is_store;
         3'b101:  acc_legal = ~bus.is_store & ~bus.eff_addr[0];
         default: acc_legal = 1'b0;
      endcase
   end

   always_comb begin
      acc_mask  = 4'b1111;
      acc_wdata = 32'h0;
      case (bus.funct3[1:0])
         2'b00: begin
            acc_mask  = 4'b0001 << bus.eff_addr[1:0];
            acc_wdata = byte_rep;
         end
         2'b01: begin
            acc_mask  = bus.eff_addr[1] ? 4'b1100 : 4'b0011;
            acc_wdata = half_rep;
         end
         default: begin
            acc_mask  = 4'b1111;
            acc_wdata = bus.store_data;
         end
      endcase
      if (!bus.is_store) begin
         acc_wdata = 32'h0;
      end
   end

   // Lane selection uses the offset captured at accept, not the live address.
   always_comb begin
      r_byte = r_bytes[addr_lo_q];
      r_half = addr_lo_q[1] ? bus.mem_r_data[31:16] : bus.mem_r_data[15:0];
      case (funct3_q)
         3'b000:  r_ext = {{24{r_byte[7]}}, r_byte};
         3'b001:  r_ext = {{16{r_half[15]}}, r_half};
         3'b100:  r_ext = {24'h0, r_byte};
         3'b101:  r_ext = {16'h0, r_half};
         default: r_ext = bus.mem_r_data;
      endcase
      if (mem_we_re_q) begin
         r_ext = 32'h0;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_request_d = 1'b0;
      mem_we_re_d   = mem_we_re_q;
      mem_masking_d = mem_masking_q;
      mem_address_d = mem_address_q;
      mem_w_data_d  = mem_w_data_q;
      funct3_d      = funct3_q;
      addr_lo_d     = addr_lo_q;
      done_d        = 1'b0;
      load_data_d   = load_data_q;
      addr_err_d    = addr_err_q;
      timeout_d     = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load_data_d = 32'h0;
               addr_err_d  = 1'b0;
               timeout_d   = 1'b0;
               if (acc_legal) begin
                  mem_we_re_d   = bus.is_store;
                  mem_masking_d = acc_mask;
                  mem_address_d = bus.eff_addr[ADDR_W+1:2];
                  mem_w_data_d  = acc_wdata;
                  funct3_d      = bus.funct3;
                  addr_lo_d     = bus.eff_addr[1:0];
                  mem_request_d = 1'b1;
                  state_d       = S_REQ;
               end else begin
                  addr_err_d = 1'b1;
                  done_d     = 1'b1;
                  state_d    = S_DONE;
               end
            end
         end
         S_REQ: begin
            wait_cnt_d = 8'h0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            // A response arriving on the expiry cycle still completes normally.
            if (bus.mem_valid) begin
               load_data_d = r_ext;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end else if (wait_cnt_q == TMO_LAST) begin
               timeout_d   = 1'b1;
               load_data_d = 32'h0;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= 8'h0;
         mem_request_q <= 1'b0;
         mem_we_re_q   <= 1'b0;
         mem_masking_q <= 4'h0;
         mem_address_q <= '0;
         mem_w_data_q  <= 32'h0;
         funct3_q      <= 3'h0;
         addr_lo_q     <= 2'h0;
         done_q        <= 1'b0;
         load_data_q   <= 32'h0;
         addr_err_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_request_q <= mem_request_d;
         mem_we_re_q   <= mem_we_re_d;
         mem_masking_q <= mem_masking_d;
         mem_address_q <= mem_address_d;
         mem_w_data_q  <= mem_w_data_d;
         funct3_q      <= funct3_d;
         addr_lo_q     <= addr_lo_d;
         done_q        <= done_d;
         load_data_q   <= load_data_d;
         addr_err_q    <= addr_err_d;
         timeout_q     <= timeout_d;
      end
   end

   assign bus.stall       = ((state_q == S_IDLE) & bus.start) |
                            (state_q == S_REQ) | (state_q == S_WAIT);
   assign bus.mem_request = mem_request_q;
   assign bus.mem_we_re   = mem_we_re_q;
   assign bus.mem_masking = mem_masking_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_w_data  = mem_w_data_q;
   assign bus.done        = done_q;
   assign bus.load_data   = load_data_q;
   assign bus.addr_err    = addr_err_q;
   assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: the bench plays the core and a
// programmable-latency memory, and checks each transaction with assertions.
module tb_load_store_unit;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Snapshot of the memory-side outputs taken in the request cycle.
   logic [31:0] req_addr;
   logic [31:0] req_mask;
   logic [31:0] req_wdata;
   logic [31:0] req_we;

   int done_cyc;
   int stall_n;
   int req_n;
   int req_cyc;

   load_store_unit_if #(.ADDR_W(8)) bus ();

   load_store_unit #(.ADDR_W(8), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one transaction starting in IDLE. lat = cycles from request to
   // mem_valid (0 = never). Cycle 0 is the start cycle. Returns in the IDLE
   // cycle after DONE, or after a 64-cycle budget.
   task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input int lat, input logic [31:0] rd);
      int cyc;
      int req_at;
      cyc      = 0;
      req_at   = -1;
      done_cyc = -1;
      stall_n  = 0;
      req_n    = 0;
      req_cyc  = -1;
      bus.start      = 1'b1;
      bus.is_store   = st;
      bus.funct3     = f3;
      bus.eff_addr   = addr;
      bus.store_data = sd;
      while (done_cyc < 0 && cyc < 64) begin
         bus.mem_valid  = (req_at >= 0) && (lat > 0) && (cyc == req_at + lat);
         bus.mem_r_data = bus.mem_valid ? rd : 32'h0;
         #1;
         if (bus.stall) stall_n++;
         if (bus.mem_request) begin
            req_n++;
            req_at    = cyc;
            req_cyc   = cyc;
            req_addr  = 32'(bus.mem_address);
            req_mask  = 32'(bus.mem_masking);
            req_wdata = bus.mem_w_data;
            req_we    = 32'(bus.mem_we_re);
         end
         if (bus.done) done_cyc = cyc;
         tick();
         bus.start     = 1'b0;
         bus.mem_valid = 1'b0;
         cyc++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b000;
      bus.eff_addr = 32'h0; bus.store_data = 32'h0;
      bus.mem_valid = 1'b0; bus.mem_r_data = 32'h0;
      tick(); tick();
      chk("reset_done",    32'(bus.done), 32'h0);
      chk("reset_request", 32'(bus.mem_request), 32'h0);
      chk("reset_stall",   32'(bus.stall), 32'h0);
      chk("reset_load",    bus.load_data, 32'h0);
      chk("reset_flags",   32'({bus.addr_err, bus.timeout}), 32'h0);
      rst = 1'b1;
      tick();

      // SW with 1-cycle memory
      run_txn(1'b1, 3'b010, 32'h0000_0014, 32'hDEAD_BEEF, 1, 32'h0);
      chk("sw_addr",     req_addr, 32'h05);
      chk("sw_mask",     req_mask, 32'hF);
      chk("sw_wdata",    req_wdata, 32'hDEAD_BEEF);
      chk("sw_we",       req_we, 32'h1);
      chk("sw_req_cyc",  32'(req_cyc), 32'd1);
      chk("sw_req_n",    32'(req_n), 32'd1);
      chk("sw_done_cyc", 32'(done_cyc), 32'd3);
      chk("sw_stall_n",  32'(stall_n), 32'd3);
      chk("sw_load",     bus.load_data, 32'h0);
      chk("done_pulse",  32'(bus.done), 32'h0);
      chk("addr_hold",   32'(bus.mem_address), 32'h05);

      // SB / SH alignment
      run_txn(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 1, 32'h0);
      chk("sb_mask",  req_mask, 32'h8);
      chk("sb_wdata", req_wdata, 32'hA5A5_A5A5);
      chk("sb_addr",  req_addr, 32'h04);
      run_txn(1'b1, 3'b001, 32'h0000_0016, 32'h1234_ABCD, 1, 32'h0);
      chk("sh_mask",  req_mask, 32'hC);
      chk("sh_wdata", req_wdata, 32'hABCD_ABCD);

      // Loads of 0x8000F0FF
      run_txn(1'b0, 3'b000, 32'h0000_0020, 32'h0, 1, 32'h8000_F0FF);
      chk("lb0",      bus.load_data, 32'hFFFF_FFFF);
      chk("lb0_mask", req_mask, 32'h1);
      chk("lb0_we",   req_we, 32'h0);
      run_txn(1'b0, 3'b100, 32'h0000_0020, 32'h0, 1, 32'h8000_F0FF);
      chk("lbu0", bus.load_data, 32'h0000_00FF);
      run_txn(1'b0, 3'b000, 32'h0000_0021, 32'h0, 1, 32'h8000_F0FF);
      chk("lb1", bus.load_data, 32'hFFFF_FFF0);
      run_txn(1'b0, 3'b100, 32'h0000_0023, 32'h0, 1, 32'h8000_F0FF);
      chk("lbu3", bus.load_data, 32'h0000_0080);
      run_txn(1'b0, 3'b001, 32'h0000_0022, 32'hFFFF_FFFF, 1, 32'h8000_F0FF);
      chk("lh2",       bus.load_data, 32'hFFFF_8000);
      chk("lh2_mask",  req_mask, 32'hC);
      chk("lh2_wdata", req_wdata, 32'h0);
      run_txn(1'b0, 3'b101, 32'h0000_0022, 32'h0, 1, 32'h8000_F0FF);
      chk("lhu2", bus.load_data, 32'h0000_8000);
      run_txn(1'b0, 3'b010, 32'h0000_0020, 32'h0, 3, 32'h8000_F0FF);
      chk("lw",          bus.load_data, 32'h8000_F0FF);
      chk("lw_done_cyc", 32'(done_cyc), 32'd5);

      // Illegal accesses
      run_txn(1'b0, 3'b001, 32'h0000_0101, 32'h0, 1, 32'h1234_5678);
      chk("lh_mis_done", 32'(done_cyc), 32'd1);
      chk("lh_mis_req",  32'(req_n), 32'd0);
      chk("lh_mis_err",  32'(bus.addr_err), 32'h1);
      chk("lh_mis_load", bus.load_data, 32'h0);
      chk("lh_mis_stall", 32'(stall_n), 32'd1);
      run_txn(1'b1, 3'b100, 32'h0000_0010, 32'hFF, 1, 32'h0);
      chk("sb100_done", 32'(done_cyc), 32'd1);
      chk("sb100_req",  32'(req_n), 32'd0);
      chk("sb100_err",  32'(bus.addr_err), 32'h1);

      // Timeouts
      run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'hFFFF_FFFF);
      chk("tmo_done_cyc", 32'(done_cyc), 32'd18);
      chk("tmo_flag",     32'(bus.timeout), 32'h1);
      chk("tmo_load",     bus.load_data, 32'h0);
      chk("tmo_err",      32'(bus.addr_err), 32'h0);
      run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 16, 32'h1357_9BDF);
      chk("edge_done_cyc", 32'(done_cyc), 32'd18);
      chk("edge_flag",     32'(bus.timeout), 32'h0);
      chk("edge_load",     bus.load_data, 32'h1357_9BDF);

      // Reset while waiting
      bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.eff_addr = 32'h0000_0080;
      tick();
      bus.start = 1'b0;
      chk("rst_req_before", 32'(bus.mem_request), 32'h1);
      tick(); tick();
      chk("rst_stall_before", 32'(bus.stall), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("rst_stall_async", 32'(bus.stall), 32'h0);
      chk("rst_req_async",   32'(bus.mem_request), 32'h0);
      bus.mem_valid = 1'b1; bus.mem_r_data = 32'hAAAA_5555;
      tick();
      chk("rst_no_done", 32'(bus.done), 32'h0);
      bus.mem_valid = 1'b0;
      #2 rst = 1'b1;
      tick();
      chk("rst_idle_done", 32'(bus.done), 32'h0);
      run_txn(1'b0, 3'b010, 32'h0000_0080, 32'h0, 1, 32'hCAFE_F00D);
      chk("post_rst_done_cyc", 32'(done_cyc), 32'd3);
      chk("post_rst_load",     bus.load_data, 32'hCAFE_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting between the core's execute stage and the data memory wrapper (request/valid handshake, word-addressed, byte-masked). It accepts one load or store per transaction, aligns store data and byte mask, issues a single-cycle memory request, waits for `valid`, then extracts and sign/zero-extends load data. While a transaction is in flight it stalls the core. It flags misaligned or illegal accesses and memory timeouts.

## Interface
- `ADDR_W`, 8, word-address width driven to memory
- `TIMEOUT`, 16, WAIT cycles without `mem_valid` before abort (2..255)
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: execute stage holds a load/store; sampled only in IDLE
- `is_store` in 1: 1 = store, 0 = load
- `funct3` in 3: RV32I width/sign code
- `eff_addr` in 32: byte effective address
- `store_data` in 32: rs2 value
- `mem_request` out 1: memory request strobe
- `mem_we_re` out 1: 1 = write, 0 = read
- `mem_masking` out 4: byte enables
- `mem_address` out ADDR_W: `eff_addr[ADDR_W+1:2]`
- `mem_w_data` out 32: lane-replicated store data
- `mem_valid` in 1: memory response valid
- `mem_r_data` in 32: read word, valid while `mem_valid`=1
- `stall` out 1: hold PC/pipeline
- `done` out 1: one-cycle completion pulse
- `load_data` out 32: extended load result, valid with `done`
- `addr_err` out 1: misaligned/illegal access, valid with `done`
- `timeout` out 1: memory timeout, valid with `done`

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset: IDLE; all outputs 0; wait counter 0.
- IDLE: on `start`, check the access. Legal store funct3: 000/001/010. Legal load funct3: 000/001/010/100/101. Halfword needs `eff_addr[0]`=0; word needs `eff_addr[1:0]`=0.
  - Legal: register `mem_we_re`, `mem_masking`, `mem_address`, `mem_w_data`, `funct3`, `eff_addr[1:0]`; go to REQ.
  - Illegal: no memory access; set `addr_err`; go to DONE.
- REQ: `mem_request`=1 for exactly this cycle; go to WAIT; clear counter.
- WAIT:
  - If `mem_valid`, capture extended `mem_r_data` (loads) into `load_data`; go to DONE.
  - Otherwise increment the counter. If the counter reaches `TIMEOUT`-1 without valid, set `timeout`, `load_data`=0, and go to DONE.
  - `mem_valid` in the same cycle as expiry: valid wins; no timeout.
- DONE: `done`=1 for one cycle; `stall`=0; go to IDLE. `load_data`, `addr_err`, `timeout` are cleared on the next accept.
- Store alignment:
  - SB: `w_data` = {4{rs2[7:0]}}, mask = 0001 << addr[1:0].
  - SH: `w_data` = {2{rs2[15:0]}}, mask = addr[1] ? 1100 : 0011.
  - SW: `w_data` = rs2, mask = 1111.
- Loads drive the same mask pattern. `w_data` is don't-care and driven 0.
- Load extraction: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Stores return `load_data`=0.
- `stall` is combinational: (IDLE & `start`) | REQ | WAIT.
- `mem_valid` outside WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE. `mem_request` and `stall` drop asynchronously; no `done`.

## Timing
- Cycle 0: IDLE, `start`=1, `stall`=1. Cycle 1: REQ, request. Cycle 2: WAIT, `mem_valid` from a 1-cycle memory. Cycle 3: DONE, `done`=1, `stall`=0.
- Minimum transaction: 4 cycles, 3 stall cycles. Each extra memory latency cycle adds one.
- Error path: cycle 0 IDLE, cycle 1 DONE with `addr_err`=1; 1 stall cycle.
- Timeout path: DONE occurs `TIMEOUT` cycles after entering WAIT.
- Back-to-back: a new `start` is accepted in the IDLE cycle after DONE; no overlap.
- `mem_*` outputs are stable from REQ until the next accept.

## Test plan
- SW: addr 0x0000_0014, rs2 0xDEADBEEF, 1-cycle memory.
  - Expect `mem_address`=0x05, mask 1111, `w_data` 0xDEADBEEF, `we_re`=1, request high one cycle.
  - Expect `done` in cycle 3; stall cycles 0–2.
- SB to addr 0x...03, rs2 0x000000A5 -> mask 1000, `w_data` 0xA5A5A5A5.
- Loads of word 0x8000_F0FF:
  - LB @+0 -> 0xFFFFFFFF; LBU @+0 -> 0x000000FF.
  - LH @+2 -> 0xFFFF8000; LHU @+2 -> 0x00008000.
  - LW -> 0x8000F0FF.
- LH at addr 0x...01, and SB with funct3=100 -> no request, `addr_err`=1 with `done` in cycle 1, `load_data`=0.
- Memory never asserts valid, `TIMEOUT`=16 -> `timeout`=1 with `done` 16 cycles after WAIT entry. Valid on the expiry cycle -> normal completion.
- `rst` low during WAIT -> request/stall 0 immediately, state IDLE, no `done`. Next load completes normally.
